divider_4_bit_seq: RTL and testbench

Iterative restoring unsigned divider: the inverse operation of the combinational 4-bit multiplier. Computes quotient and remainder of a/b, one quotient bit per clock, behind a start/done handshake. Used wherever a product must be decomposed back into factors. Results also let a bench close the loop, since a == quotient*b + remainder can be checked through multiplier_4_bit.

---
 rtl/divider_4_bit_seq_pkg.sv | 19 +
 rtl/divider_4_bit_seq_if.sv | 27 ++
 rtl/divider_4_bit_seq_div_restore_step.sv | 27 ++
 rtl/divider_4_bit_seq.sv | 94 +++++++++
 tb/tb_divider_4_bit_seq.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/divider_4_bit_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// iteration counter sizing and the FSM state encoding.
package divider_4_bit_seq_pkg;

    localparam int DIV_WIDTH = 4;

    // The counter has to hold the value WIDTH itself, so it needs one extra code.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } div_state_t;

endpackage

// File: rtl/divider_4_bit_seq_if.sv
// Start/done handshake plus operand and result bus of the sequential divider.
interface divider_4_bit_seq_if
    import divider_4_bit_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  quotient, remainder, done, busy, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output quotient, remainder, done, busy, div_by_zero
    );

endinterface

// File: rtl/divider_4_bit_seq_div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_restore_step
    import divider_4_bit_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] partial_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] partial_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The stored partial is always below the divisor, so it fits in WIDTH bits;
    // only the shifted value and the trial need the extra bit, whose MSB is the sign.
    always_comb begin
        shifted     = {partial_in, dividend_bit};
        trial       = shifted - {1'b0, divisor};
        q_bit       = ~trial[WIDTH];
        partial_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_4_bit_seq.sv
// Iterative unsigned restoring divider producing one quotient bit per clock
// behind a start/done handshake, with a one-cycle divide-by-zero shortcut.
module divider_4_bit_seq
    import divider_4_bit_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    divider_4_bit_seq_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] quo_r;
    logic             zero_pending;

    logic [WIDTH-1:0] partial_next;
    logic             q_bit;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .partial_in   (partial),
        .dividend_bit (dividend_r[WIDTH-1]),
        .divisor      (divisor_r),
        .partial_out  (partial_next),
        .q_bit        (q_bit)
    );

    // A zero divisor stays in IDLE for one extra edge via zero_pending so its
    // result appears one cycle after acceptance; start is not taken meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            dividend_r      <= '0;
            divisor_r       <= '0;
            partial         <= '0;
            quo_r           <= '0;
            zero_pending    <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.done        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (zero_pending) begin
                        zero_pending    <= 1'b0;
                        bus.quotient    <= '1;
                        bus.remainder   <= dividend_r;
                        bus.div_by_zero <= 1'b1;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                    end else if (bus.start) begin
                        dividend_r <= bus.a;
                        divisor_r  <= bus.b;
                        partial    <= '0;
                        quo_r      <= '0;
                        count      <= CW'(WIDTH);
                        bus.busy   <= 1'b1;
                        if (bus.b == '0) begin
                            zero_pending <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    partial    <= partial_next;
                    quo_r      <= {quo_r[WIDTH-2:0], q_bit};
                    dividend_r <= {dividend_r[WIDTH-2:0], 1'b0};
                    count      <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state           <= IDLE;
                        bus.quotient    <= {quo_r[WIDTH-2:0], q_bit};
                        bus.remainder   <= partial_next;
                        bus.div_by_zero <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_4_bit_seq.sv
// Self-checking bench for divider_4_bit_seq: directed scenarios, an exhaustive
// back-to-back sweep and random operands, all compared against plain / and %.
module tb_divider_4_bit_seq;
    import divider_4_bit_seq_pkg::*;

    localparam int W = DIV_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    divider_4_bit_seq_if #(.WIDTH(W)) bus ();

    divider_4_bit_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int max_cycles, inout int lat);
        while (!bus.done && lat < max_cycles) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Reference: plain integer division; divide-by-zero gives all ones and a.
    task automatic checkResult(input string tag, input int a, input int b, input int lat);
        int exp_q, exp_r, exp_lat;
        exp_q   = (b == 0) ? (1 << W) - 1 : a / b;
        exp_r   = (b == 0) ? a : a % b;
        exp_lat = (b == 0) ? 1 : W;
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_done"}, bus.done, 1'b1);
        checkOutput({tag, "_busy"}, bus.busy, 1'b0);
        checkOutput({tag, "_quotient"}, bus.quotient, exp_q);
        checkOutput({tag, "_remainder"}, bus.remainder, exp_r);
        checkOutput({tag, "_dbz"}, bus.div_by_zero, (b == 0));
        if (b != 0) begin
            checkOutput({tag, "_identity"},
                        int'(bus.quotient) * b + int'(bus.remainder), a);
            checkOutput({tag, "_rem_lt_b"}, (int'(bus.remainder) < b), 1'b1);
        end
    endtask

    task automatic runOp(input string tag, input int a, input int b);
        int lat;
        lat = 0;
        applyStimulus(W'(a), W'(b));
        checkOutput({tag, "_done_low_at_accept"}, bus.done, 1'b0);
        waitDone(W + 3, lat);
        checkResult(tag, a, b, lat);
    endtask

    task automatic expectQuiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput({tag, "_no_done"}, bus.done, 1'b0);
            checkOutput({tag, "_idle"}, bus.busy, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int lat;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_quotient", bus.quotient, 0);
        checkOutput("reset_remainder", bus.remainder, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] 13/3 with busy tracking");
        applyStimulus(4'd13, 4'd3);
        for (int i = 0; i < W; i++) begin
            checkOutput($sformatf("busy_cycle%0d", i), bus.busy, 1'b1);
            checkOutput($sformatf("done_low_cycle%0d", i), bus.done, 1'b0);
            checkOutput($sformatf("hold_quotient_cycle%0d", i), bus.quotient, 0);
            @(negedge clk);
        end
        checkResult("div13_3", 13, 3, W);

        $display("[TB] directed back-to-back operations");
        runOp("div15_1", 15, 1);
        runOp("div0_5", 0, 5);
        runOp("div3_7", 3, 7);
        runOp("div7_0", 7, 0);
        runOp("div6_2", 6, 2);

        $display("[TB] start while busy is ignored");
        applyStimulus(4'd9, 4'd2);
        @(negedge clk);
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 2;
        waitDone(W + 3, lat);
        checkResult("div9_2_ignore", 9, 2, lat);
        expectQuiet("after_ignore", 6);

        $display("[TB] reset in the middle of a calculation");
        applyStimulus(4'd14, 4'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_quotient", bus.quotient, 0);
        checkOutput("midreset_remainder", bus.remainder, 0);
        checkOutput("midreset_busy", bus.busy, 0);
        checkOutput("midreset_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        expectQuiet("after_reset", 6);
        runOp("div14_3", 14, 3);

        $display("[TB] exhaustive sweep");
        for (int i = 0; i < 256; i++) begin
            runOp($sformatf("sweep_%0d_%0d", i / 16, i % 16), i / 16, i % 16);
        end

        $display("[TB] random operands with random gaps");
        for (int i = 0; i < 40; i++) begin
            int ra, rb, gap;
            ra  = int'($urandom_range(0, 15));
            rb  = int'($urandom_range(0, 15));
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            runOp($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
